// File: rtl/vit_ctrl_322_if.sv
// Signal bundle between the (3,2,2) Viterbi frame controller and its neighbours
// (branch-metric front end, ACS unit, traceback unit).
interface vit_ctrl_322_if #(
    parameter int W  = 8,
    parameter int CW = 6
);
    logic          start;
    logic          sym_valid;
    logic          sym_ready;
    logic [W-1:0]  acs0_ppm;
    logic [W-1:0]  acs1_ppm;
    logic [W-1:0]  acs2_ppm;
    logic [W-1:0]  acs3_ppm;
    logic [W-1:0]  acs4_ppm;
    logic [W-1:0]  acs5_ppm;
    logic [W-1:0]  acs6_ppm;
    logic [W-1:0]  acs7_ppm;
    logic          ae;
    logic          init_pm;
    logic          flush;
    logic          norm_en;
    logic [W-1:0]  norm_val;
    logic [CW-1:0] stage_cnt;
    logic          tb_start;
    logic          tb_done;
    logic          busy;
    logic          frame_done;
    logic [7:0]    norm_count;

    modport master (
        input  start, sym_valid, tb_done,
        input  acs0_ppm, acs1_ppm, acs2_ppm, acs3_ppm,
        input  acs4_ppm, acs5_ppm, acs6_ppm, acs7_ppm,
        output sym_ready, ae, init_pm, flush, norm_en, norm_val,
        output stage_cnt, tb_start, busy, frame_done, norm_count
    );

    modport slave (
        output start, sym_valid, tb_done,
        output acs0_ppm, acs1_ppm, acs2_ppm, acs3_ppm,
        output acs4_ppm, acs5_ppm, acs6_ppm, acs7_ppm,
        input  sym_ready, ae, init_pm, flush, norm_en, norm_val,
        input  stage_cnt, tb_start, busy, frame_done, norm_count
    );
endinterface

// File: rtl/vit_ctrl_322.sv
// Frame controller for the 8-state (3,2,2) Viterbi decoder: sequences init, symbol
// stages, tail flush and traceback, and schedules path-metric normalisation.
module vit_ctrl_322 #(
    parameter int W         = 8,
    parameter int FRAME_LEN = 32,
    parameter int TAIL      = 2,
    parameter int NORM_THR  = 128,
    parameter int CW        = $clog2(FRAME_LEN + TAIL)
) (
    input  logic           clock,
    input  logic           reset,
    vit_ctrl_322_if.master bus
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_INIT  = 3'd1;
    localparam logic [2:0] S_RUN   = 3'd2;
    localparam logic [2:0] S_FLUSH = 3'd3;
    localparam logic [2:0] S_TB    = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    localparam logic [CW-1:0] LAST_RUN   = CW'(FRAME_LEN - 1);
    localparam logic [CW-1:0] LAST_FLUSH = CW'(FRAME_LEN + TAIL - 1);
    localparam logic [W-1:0]  THR        = W'(NORM_THR);

    logic [2:0]    r_state;
    logic [2:0]    w_next;
    logic [CW-1:0] r_stage_cnt;
    logic [7:0]    r_norm_count;
    logic [W-1:0]  r_min;
    logic          r_norm_hold;
    logic          r_tb_start;
    logic          w_ready;
    logic          w_ae;
    logic          w_norm_en;
    logic [W-1:0]  w_min;
    logic [W-1:0]  w_ppm [8];

    assign w_ppm[0] = bus.acs0_ppm;
    assign w_ppm[1] = bus.acs1_ppm;
    assign w_ppm[2] = bus.acs2_ppm;
    assign w_ppm[3] = bus.acs3_ppm;
    assign w_ppm[4] = bus.acs4_ppm;
    assign w_ppm[5] = bus.acs5_ppm;
    assign w_ppm[6] = bus.acs6_ppm;
    assign w_ppm[7] = bus.acs7_ppm;

    always_comb begin
        w_min = w_ppm[0];
        for (int i = 1; i < 8; i++) begin
            if (w_ppm[i] < w_min) w_min = w_ppm[i];
        end
    end

    assign w_ready = (r_state == S_RUN);
    assign w_ae    = (w_ready && bus.sym_valid) || (r_state == S_FLUSH);
    // r_min is one cycle stale; the holdoff skips the cycle where it still shows the pre-subtract minimum
    assign w_norm_en = w_ae && (r_min >= THR) && !r_norm_hold;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (bus.start) w_next = S_INIT;
            S_INIT:  w_next = S_RUN;
            S_RUN:   if (w_ae && (r_stage_cnt == LAST_RUN)) w_next = (TAIL > 0) ? S_FLUSH : S_TB;
            S_FLUSH: if (r_stage_cnt == LAST_FLUSH) w_next = S_TB;
            S_TB:    if (bus.tb_done) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_stage_cnt  <= '0;
            r_norm_count <= '0;
            r_min        <= '0;
            r_norm_hold  <= 1'b0;
            r_tb_start   <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_min       <= w_min;
            r_norm_hold <= w_norm_en;
            r_tb_start  <= (w_next == S_TB) && (r_state != S_TB);
            if ((r_state == S_IDLE) && bus.start) begin
                r_stage_cnt  <= '0;
                r_norm_count <= '0;
            end else begin
                if (w_ae) r_stage_cnt <= r_stage_cnt + 1'b1;
                if (w_norm_en && (r_norm_count != 8'hFF)) r_norm_count <= r_norm_count + 1'b1;
            end
        end
    end

    assign bus.sym_ready  = w_ready;
    assign bus.ae         = w_ae;
    assign bus.init_pm    = (r_state == S_INIT);
    assign bus.flush      = (r_state == S_FLUSH);
    assign bus.norm_en    = w_norm_en;
    assign bus.norm_val   = w_norm_en ? THR : '0;
    assign bus.stage_cnt  = r_stage_cnt;
    assign bus.tb_start   = r_tb_start;
    assign bus.busy       = (r_state != S_IDLE);
    assign bus.frame_done = (r_state == S_DONE);
    assign bus.norm_count = r_norm_count;
endmodule

// File: tb/tb_vit_ctrl_322.sv
// Directed bench for vit_ctrl_322: a per-cycle vector table for one full frame,
// then hand sequences for alternation, normalisation, reset and saturation.
module tb_vit_ctrl_322;
    localparam int W   = 8;
    localparam int FL  = 32;
    localparam int TL  = 2;
    localparam int CW  = $clog2(FL + TL);
    localparam int FL2 = 520;
    localparam int CW2 = $clog2(FL2 + TL);

    localparam logic [7:0] F_RDY  = 8'h80;
    localparam logic [7:0] F_AE   = 8'h40;
    localparam logic [7:0] F_INIT = 8'h20;
    localparam logic [7:0] F_FL   = 8'h10;
    localparam logic [7:0] F_NORM = 8'h08;
    localparam logic [7:0] F_TBS  = 8'h04;
    localparam logic [7:0] F_BUSY = 8'h02;
    localparam logic [7:0] F_DONE = 8'h01;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    vit_ctrl_322_if #(.W(W), .CW(CW))  bus_a ();
    vit_ctrl_322_if #(.W(W), .CW(CW2)) bus_b ();

    vit_ctrl_322 #(.W(W), .FRAME_LEN(FL), .TAIL(TL), .NORM_THR(128)) u_dut (
        .clock (clk),
        .reset (rst_n),
        .bus   (bus_a.master)
    );

    vit_ctrl_322 #(.W(W), .FRAME_LEN(FL2), .TAIL(TL), .NORM_THR(128)) u_sat (
        .clock (clk),
        .reset (rst_n),
        .bus   (bus_b.master)
    );

    typedef struct {
        int         n;
        logic       st;
        logic       sv;
        logic       tbd;
        logic [7:0] flags;
        int         cnt0;
        int         ncnt;
    } vec_t;

    vec_t vt [10];
    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic logic [7:0] flags_a();
        return {bus_a.sym_ready, bus_a.ae, bus_a.init_pm, bus_a.flush,
                bus_a.norm_en, bus_a.tb_start, bus_a.busy, bus_a.frame_done};
    endfunction

    task automatic set_ppm_a(input logic [7:0] v, input logic [7:0] v0);
        bus_a.acs0_ppm = v0;
        bus_a.acs1_ppm = v;  bus_a.acs2_ppm = v;  bus_a.acs3_ppm = v;
        bus_a.acs4_ppm = v;  bus_a.acs5_ppm = v;  bus_a.acs6_ppm = v;
        bus_a.acs7_ppm = v;
    endtask

    task automatic set_ppm_b(input logic [7:0] v);
        bus_b.acs0_ppm = v;  bus_b.acs1_ppm = v;  bus_b.acs2_ppm = v;
        bus_b.acs3_ppm = v;  bus_b.acs4_ppm = v;  bus_b.acs5_ppm = v;
        bus_b.acs6_ppm = v;  bus_b.acs7_ppm = v;
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int ecnt;
        bit seen;

        // Full frame, sym_valid high, tb_done 3 cycles after tb_start
        vt[0] = '{1,  1'b0, 1'b0, 1'b0, 8'h00,                  0,  0};
        vt[1] = '{1,  1'b1, 1'b1, 1'b1, 8'h00,                  0,  0};
        vt[2] = '{1,  1'b1, 1'b1, 1'b0, F_INIT | F_BUSY,        0,  0};
        vt[3] = '{32, 1'b0, 1'b1, 1'b0, F_RDY | F_AE | F_BUSY,  0,  0};
        vt[4] = '{2,  1'b0, 1'b1, 1'b0, F_AE | F_FL | F_BUSY,   32, 0};
        vt[5] = '{1,  1'b0, 1'b1, 1'b0, F_TBS | F_BUSY,         34, 0};
        vt[6] = '{2,  1'b0, 1'b1, 1'b0, F_BUSY,                 34, 0};
        vt[7] = '{1,  1'b0, 1'b0, 1'b1, F_BUSY,                 34, 0};
        vt[8] = '{1,  1'b1, 1'b0, 1'b0, F_DONE | F_BUSY,        34, 0};
        vt[9] = '{1,  1'b0, 1'b0, 1'b0, 8'h00,                  34, 0};

        bus_a.start = 1'b0; bus_a.sym_valid = 1'b0; bus_a.tb_done = 1'b0;
        bus_b.start = 1'b0; bus_b.sym_valid = 1'b0; bus_b.tb_done = 1'b0;
        set_ppm_a(8'd0, 8'd0);
        set_ppm_b(8'd0);

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset flags", 32'(flags_a()), 32'(8'h00));
        chk("reset stage_cnt", 32'(bus_a.stage_cnt), 32'd0);
        chk("reset norm_count", 32'(bus_a.norm_count), 32'd0);
        chk("reset norm_val", 32'(bus_a.norm_val), 32'd0);
        next_cyc();
        rst_n = 1'b1;

        for (int r = 0; r < 10; r++) begin
            for (int k = 0; k < vt[r].n; k++) begin
                bus_a.start     = vt[r].st;
                bus_a.sym_valid = vt[r].sv;
                bus_a.tb_done   = vt[r].tbd;
                @(negedge clk);
                ecnt = vt[r].cnt0 + (((vt[r].flags & F_AE) != 8'h00) ? k : 0);
                chk($sformatf("vec%0d.%0d flags", r, k), 32'(flags_a()), 32'(vt[r].flags));
                chk($sformatf("vec%0d.%0d stage_cnt", r, k), 32'(bus_a.stage_cnt), 32'(ecnt));
                chk($sformatf("vec%0d.%0d norm_count", r, k), 32'(bus_a.norm_count), 32'(vt[r].ncnt));
                next_cyc();
            end
        end

        // Alternating sym_valid, with stray start and tb_done during RUN
        bus_a.start = 1'b1; bus_a.sym_valid = 1'b0; bus_a.tb_done = 1'b0;
        next_cyc();
        bus_a.start = 1'b0;
        @(negedge clk);
        chk("alt init flags", 32'(flags_a()), 32'(F_INIT | F_BUSY));
        chk("alt init stage_cnt", 32'(bus_a.stage_cnt), 32'd0);
        next_cyc();
        for (int i = 0; i < 64; i++) begin
            bus_a.sym_valid = (i % 2 == 1);
            bus_a.start     = (i == 10);
            bus_a.tb_done   = (i == 20);
            @(negedge clk);
            chk($sformatf("alt%0d flags", i), 32'(flags_a()),
                32'(F_RDY | F_BUSY | ((i % 2 == 1) ? F_AE : 8'h00)));
            chk($sformatf("alt%0d stage_cnt", i), 32'(bus_a.stage_cnt), 32'(i / 2));
            next_cyc();
        end
        bus_a.start = 1'b0; bus_a.tb_done = 1'b0; bus_a.sym_valid = 1'b0;
        @(negedge clk);
        chk("alt flush1 flags", 32'(flags_a()), 32'(F_AE | F_FL | F_BUSY));
        chk("alt flush1 stage_cnt", 32'(bus_a.stage_cnt), 32'd32);
        next_cyc();
        @(negedge clk);
        chk("alt flush2 stage_cnt", 32'(bus_a.stage_cnt), 32'd33);
        next_cyc();
        bus_a.tb_done = 1'b1;
        @(negedge clk);
        chk("tb same-cycle flags", 32'(flags_a()), 32'(F_TBS | F_BUSY));
        next_cyc();
        bus_a.tb_done = 1'b0;
        @(negedge clk);
        chk("tb same-cycle done", 32'(flags_a()), 32'(F_DONE | F_BUSY));
        next_cyc();
        @(negedge clk);
        chk("alt idle flags", 32'(flags_a()), 32'(8'h00));
        next_cyc();

        // Normalisation with min 200, then one metric dropped to 127
        set_ppm_a(8'd200, 8'd200);
        bus_a.start = 1'b1;
        next_cyc();
        bus_a.start = 1'b0;
        next_cyc();
        for (int i = 0; i < 6; i++) begin
            bus_a.sym_valid = 1'b1;
            @(negedge clk);
            chk($sformatf("norm%0d en", i), 32'(bus_a.norm_en), 32'(i % 2 == 0));
            chk($sformatf("norm%0d val", i), 32'(bus_a.norm_val), (i % 2 == 0) ? 32'd128 : 32'd0);
            chk($sformatf("norm%0d count", i), 32'(bus_a.norm_count), 32'((i + 1) / 2));
            next_cyc();
        end
        set_ppm_a(8'd200, 8'd127);
        bus_a.sym_valid = 1'b0;
        repeat (2) begin
            @(negedge clk);
            chk("norm gap en", 32'(bus_a.norm_en), 32'd0);
            next_cyc();
        end
        for (int i = 0; i < 4; i++) begin
            bus_a.sym_valid = 1'b1;
            @(negedge clk);
            chk($sformatf("low%0d en", i), 32'(bus_a.norm_en), 32'd0);
            chk($sformatf("low%0d count", i), 32'(bus_a.norm_count), 32'd3);
            next_cyc();
        end
        @(negedge clk);
        chk("pre-reset stage_cnt", 32'(bus_a.stage_cnt), 32'd10);

        // Reset mid-RUN, then a fresh frame restarts from zero
        rst_n = 1'b0;
        next_cyc();
        @(negedge clk);
        chk("midrun reset flags", 32'(flags_a()), 32'(8'h00));
        chk("midrun reset stage_cnt", 32'(bus_a.stage_cnt), 32'd0);
        chk("midrun reset norm_count", 32'(bus_a.norm_count), 32'd0);
        next_cyc();
        rst_n = 1'b1;
        set_ppm_a(8'd200, 8'd200);
        bus_a.start = 1'b1;
        next_cyc();
        bus_a.start = 1'b0;
        next_cyc();
        @(negedge clk);
        chk("restart flags", 32'(flags_a()), 32'(F_RDY | F_AE | F_BUSY | F_NORM));
        chk("restart stage_cnt", 32'(bus_a.stage_cnt), 32'd0);
        next_cyc();
        @(negedge clk);
        chk("restart stage_cnt 1", 32'(bus_a.stage_cnt), 32'd1);
        chk("restart norm_count 1", 32'(bus_a.norm_count), 32'd1);
        next_cyc();

        // norm_count saturation on the long-frame instance
        set_ppm_b(8'd255);
        bus_b.sym_valid = 1'b1;
        bus_b.start     = 1'b1;
        next_cyc();
        bus_b.start = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 2000 && !seen; c++) begin
            @(negedge clk);
            if (bus_b.tb_start) seen = 1'b1;
            else next_cyc();
        end
        chk("sat tb_start seen", 32'(seen), 32'd1);
        if (seen) begin
            chk("sat stage_cnt", 32'(bus_b.stage_cnt), 32'(FL2 + TL));
            next_cyc();
            bus_b.tb_done = 1'b1;
            next_cyc();
            bus_b.tb_done = 1'b0;
            @(negedge clk);
            chk("sat frame_done", 32'(bus_b.frame_done), 32'd1);
            chk("sat norm_count", 32'(bus_b.norm_count), 32'd255);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
